// File: rtl/ss_ddr_bridge.sv
// ss_ddr_bridge: turns the savestate toggle req/ack port into single-beat DDRAM
// commands inside the savestate window, with a watchdog for lost read data.
module ss_ddr_bridge #(
  parameter logic [28:0] BASE_WORD = 29'h07C0_0000,
  parameter int unsigned TIMEOUT   = 4095
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [18:0] ss_addr,
  input  logic [63:0] ss_do,
  input  logic        ss_we,
  input  logic [7:0]  ss_be,
  input  logic        ss_req,
  output logic        ss_ack,
  output logic [63:0] ss_di,
  input  logic        ddram_busy,
  output logic [7:0]  ddram_burstcnt,
  output logic [28:0] ddram_addr,
  output logic        ddram_rd,
  output logic        ddram_we,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_dout_ready,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;
  localparam logic [11:0] WD_LAST = 12'(TIMEOUT - 1);
  state_t      state, state_nx;
  logic        ss_ack_nx, ddram_rd_nx, ddram_we_nx, timeout_err_nx;
  logic [63:0] ss_di_nx, ddram_din_nx;
  logic [28:0] ddram_addr_nx;
  logic [7:0]  ddram_be_nx;
  logic [11:0] wd, wd_nx;
  assign ddram_burstcnt = 8'd1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ss_ack      <= 1'b0;
      ss_di       <= 64'h0;
      ddram_rd    <= 1'b0;
      ddram_we    <= 1'b0;
      ddram_addr  <= 29'h0;
      ddram_din   <= 64'h0;
      ddram_be    <= 8'hFF;
      timeout_err <= 1'b0;
      wd          <= 12'h0;
    end else begin
      state       <= state_nx;
      ss_ack      <= ss_ack_nx;
      ss_di       <= ss_di_nx;
      ddram_rd    <= ddram_rd_nx;
      ddram_we    <= ddram_we_nx;
      ddram_addr  <= ddram_addr_nx;
      ddram_din   <= ddram_din_nx;
      ddram_be    <= ddram_be_nx;
      timeout_err <= timeout_err_nx;
      wd          <= wd_nx;
    end
  end
  always_comb begin
    state_nx       = state;
    ss_ack_nx      = ss_ack;
    ss_di_nx       = ss_di;
    ddram_rd_nx    = ddram_rd;
    ddram_we_nx    = ddram_we;
    ddram_addr_nx  = ddram_addr;
    ddram_din_nx   = ddram_din;
    ddram_be_nx    = ddram_be;
    timeout_err_nx = timeout_err;
    wd_nx          = wd;
    case (state)
      IDLE: if (ss_req != ss_ack) begin
        ddram_addr_nx = BASE_WORD + {10'd0, ss_addr};
        ddram_din_nx  = ss_do;
        ddram_be_nx   = ss_we ? ss_be : 8'hFF;
        ddram_we_nx   = ss_we;
        ddram_rd_nx   = !ss_we;
        state_nx      = ss_we ? WR_ISSUE : RD_ISSUE;
      end
      WR_ISSUE: if (!ddram_busy) begin
        ddram_we_nx = 1'b0;
        ss_ack_nx   = !ss_ack;
        state_nx    = IDLE;
      end
      RD_ISSUE: if (!ddram_busy) begin
        ddram_rd_nx = 1'b0;
        wd_nx       = 12'h0;
        state_nx    = RD_WAIT;
      end
      RD_WAIT:
        // data and ack move together so req==ack always implies valid ss_di
        if (ddram_dout_ready) begin
          ss_di_nx  = ddram_dout;
          ss_ack_nx = !ss_ack;
          state_nx  = IDLE;
        end else if (wd == WD_LAST) begin
          ss_di_nx       = 64'h0;
          ss_ack_nx      = !ss_ack;
          timeout_err_nx = 1'b1;
          state_nx       = IDLE;
        end else begin
          wd_nx = wd + 12'd1;
        end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ss_ddr_bridge.sv
// tb_ss_ddr_bridge: scoreboard bench; a DDR responder checks commands, a monitor checks acks.
module tb_ss_ddr_bridge;
  localparam int TO = 16;
  localparam logic [28:0] BASE = 29'h07C0_0000;
  typedef struct { bit we; logic [28:0] addr; logic [63:0] din; logic [7:0] be; } cmd_t;
  typedef struct { logic [63:0] di; bit terr; } rsp_t;
  logic clk = 0, reset_n = 0;
  logic [18:0] ss_addr = 0;
  logic [63:0] ss_do = 0, ss_di, ddram_din, ddram_dout = 0;
  logic ss_we = 0, ss_req = 0, ss_ack, ddram_busy = 0, ddram_rd, ddram_we, ddram_dout_ready = 0, timeout_err;
  logic [7:0] ss_be = 0, ddram_burstcnt, ddram_be;
  logic [28:0] ddram_addr;
  int tests = 0, errors = 0;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int busy_pct = 0, busy_cycles = 0, rd_delay = 1, last_hold = 0;
  bit rd_drop = 0, stray_en = 0;
  logic [63:0] rd_data = 0, m_di = 0;
  bit m_terr = 0;

  ss_ddr_bridge #(.BASE_WORD(BASE), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ss_addr(ss_addr), .ss_do(ss_do), .ss_we(ss_we), .ss_be(ss_be),
    .ss_req(ss_req), .ss_ack(ss_ack), .ss_di(ss_di), .ddram_busy(ddram_busy),
    .ddram_burstcnt(ddram_burstcnt), .ddram_addr(ddram_addr), .ddram_rd(ddram_rd), .ddram_we(ddram_we),
    .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_dout(ddram_dout),
    .ddram_dout_ready(ddram_dout_ready), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // DDR responder and command monitor
  initial begin
    int cnt = 0, act = 0;
    bit unstable = 0;
    logic [101:0] snap = 0;
    cmd_t c;
    forever begin
      @(negedge clk);
      ddram_dout_ready = 0;
      if (!reset_n) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !rd_drop) begin ddram_dout_ready = 1; ddram_dout = rd_data; end
      end else if (stray_en && $urandom_range(0, 2) == 0) begin
        ddram_dout_ready = 1;
        ddram_dout = {$urandom, $urandom};
      end
      if (ddram_rd || ddram_we) begin
        ddram_busy = (act < busy_cycles) || ($urandom_range(0, 99) < busy_pct);
        if (act == 0) begin
          snap = {ddram_addr, ddram_din, ddram_be, ddram_rd};
          unstable = 0;
        end else if (snap != {ddram_addr, ddram_din, ddram_be, ddram_rd}) unstable = 1;
        act++;
        if (!ddram_busy) begin
          last_hold = act;
          act = 0;
          if (cmd_q.size() == 0) check("unexpected_cmd", {ddram_rd, ddram_we, ddram_addr}, 0);
          else begin
            c = cmd_q.pop_front();
            check("cmd", {ddram_rd, ddram_we, ddram_addr, ddram_din, ddram_be, ddram_burstcnt, unstable},
                  {!c.we, c.we, c.addr, c.din, c.be, 8'd1, 1'b0});
          end
          if (ddram_rd) cnt = rd_delay;
        end
      end else begin
        act = 0;
        ddram_busy = ($urandom_range(0, 99) < busy_pct);
      end
    end
  end

  // response monitor: every ack toggle must match the oldest expected response
  initial begin
    logic prev_ack = 0;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!reset_n) prev_ack = 0;
      else if (ss_ack != prev_ack) begin
        prev_ack = ss_ack;
        if (rsp_q.size() == 0) check("unexpected_ack", {ss_di, timeout_err}, {m_di, 1'b1});
        else begin
          r = rsp_q.pop_front();
          check("rsp", {ss_di, timeout_err}, {r.di, r.terr});
        end
      end
    end
  end

  task automatic txn(input bit we, input logic [18:0] a, input logic [63:0] d, input logic [7:0] be,
                     input int dly, input bit drop, input logic [63:0] rdat, output int lat);
    cmd_t c;
    rsp_t r;
    c.we = we; c.addr = BASE + 29'(a); c.din = d; c.be = we ? be : 8'hFF;
    cmd_q.push_back(c);
    if (!we) begin
      rd_delay = dly; rd_drop = drop; rd_data = rdat;
      if (drop || dly > TO) begin m_di = 0; m_terr = 1; end
      else m_di = rdat;
    end
    r.di = m_di; r.terr = m_terr;
    rsp_q.push_back(r);
    ss_addr = a; ss_do = d; ss_we = we; ss_be = be;
    ss_req = ~ss_req;
    lat = 0;
    while (ss_ack != ss_req && lat < 300) begin @(negedge clk); lat++; end
    if (ss_ack != ss_req) check("ack_wait", 1, 0);
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    check("rst_ctl", {ss_ack, ddram_rd, ddram_we, timeout_err, ddram_be, ddram_burstcnt}, {4'b0, 8'hFF, 8'd1});
    check("rst_data", {ss_di, ddram_din, ddram_addr}, 0);
    reset_n = 1;
    @(negedge clk);
    txn(1, 19'h00001, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 0, 0, lat);
    check("wr_lat", lat, 2);
    check("wr_hold", last_hold, 1);
    busy_cycles = 5;
    txn(1, 19'h00042, {$urandom, $urandom}, 8'h3C, 0, 0, 0, lat);
    busy_cycles = 0;
    check("wr_bp_lat", lat, 7);
    check("wr_bp_hold", last_hold, 6);
    txn(0, 19'h00001, 64'h0, 8'h00, 10, 0, 64'h0000_0000_5345_4E53, lat);
    check("rd_lat", lat, 12);
    stray_en = 1;
    repeat (10) @(negedge clk);
    check("stray_idle", {ss_ack, ss_di}, {ss_req, m_di});
    txn(1, 19'h7FFFF, {$urandom, $urandom}, 8'h81, 0, 0, 0, lat);
    stray_en = 0;
    check("slot3_lat", lat, 2);
    txn(0, 19'h12345, 64'h0, 8'h00, TO, 0, 64'hDEAD_BEEF_0BAD_F00D, lat);
    check("rd_edge_lat", lat, TO + 2);
    txn(0, 19'h00007, 64'h0, 8'h00, 1, 1, 0, lat);
    check("rd_to_lat", lat, TO + 2);
    txn(0, 19'h00008, 64'h0, 8'h00, 3, 0, 64'h1122_3344_5566_7788, lat);
    check("rd_after_to", lat, 5);
    busy_pct = 30;
    for (int i = 0; i < 40; i++) begin
      bit we = 1'($urandom_range(0, 1));
      stray_en = we;
      txn(we, 19'($urandom), {$urandom, $urandom}, 8'($urandom), $urandom_range(1, TO + 3),
          ($urandom_range(0, 9) == 0), {$urandom, $urandom}, lat);
      stray_en = 0;
    end
    busy_pct = 0;
    busy_cycles = 1000;
    ss_we = 0; ss_addr = 19'h00005;
    ss_req = ~ss_req;
    repeat (3) @(negedge clk);
    reset_n = 0;
    #1;
    check("rst_mid", {ddram_rd, ss_ack, timeout_err}, 0);
    cmd_q.delete(); rsp_q.delete();
    m_di = 0; m_terr = 0; ss_req = 0; busy_cycles = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    txn(0, 19'h00009, 64'h0, 8'h00, 4, 0, 64'hCAFE_F00D_1234_5678, lat);
    check("rd_post_rst", lat, 6);
    repeat (5) @(negedge clk);
    check("drain", cmd_q.size() + rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
